crossfade_sequencer: RTL
========================

// Module: crossfade_sequencer
// PURPOSE
//  Automatic crossfade controller for the two-channel audio mixer. Accepts a target
//  weight1 value and a step rate, then emits single-cycle fup/fdown pulses on the
//  mixer's controls bus, one weight step per RATE audio samples, until the target is met.
//  Sits between the button/switch debouncers and the mixer's controls[9:0] input.
//  Reads back the mixer's weight1 to confirm each step.
// PARAMETERS
//  MAX_WEIGHT   5'd31  top of the weight1 range; target is clamped to this value
//  ACK_TIMEOUT  8      cycles to wait for a weight1 change after a step pulse
//  RATE_W       8      width of the rate input (audio samples per step)
// PORTS
//  clock        in   1       system clock
//  reset        in   1       synchronous, active-high
//  ready        in   1       one-cycle audio sample strobe (~48 kHz)
//  start        in   1       one-cycle pulse: begin a crossfade to target
//  abort        in   1       one-cycle pulse: cancel the crossfade in progress
//  target       in   5       desired weight1 value
//  rate         in   RATE_W  ready strobes per step; 0 is treated as 1
//  weight1      in   5       readback of the mixer's weight1
//  man_fup      in   1       manual fader-up (debounced); passed through only when idle
//  man_fdown    in   1       manual fader-down (debounced); passed through only when idle
//  src_sel      in   8       mixer output-tap select
//  controls     out  10      to mixer: {fdown, fup, switches[7:0]}, all registered
//  busy         out  1       high while a crossfade is in progress
//  done         out  1       one-cycle pulse when a crossfade completes
//  err          out  1       sticky; set on step-ack timeout, cleared by reset or next start
// BEHAVIOUR
//  - Reset: state=IDLE; controls=0; busy=0; done=0; err=0; all counters=0.
//  - controls[7:0] <= src_sel every cycle, including while busy.
//  - IDLE: controls[8] <= man_fup, controls[9] <= man_fdown. start is sampled only here.
//    - On start: latch tgt=min(target,MAX_WEIGHT) and rate (0->1); clear err.
//    - If tgt==weight1: go to FINISH. Otherwise go to WAIT_RATE.
//    - busy rises the cycle after start.
//  - While busy, manual inputs are ignored and start is ignored.
//  - WAIT_RATE: count ready strobes.
//    - When count==rate: clear count, latch wprev=weight1, go to PULSE.
//  - PULSE (1 cycle):
//    - weight1<tgt: fup=1. weight1>tgt: fdown=1. Never both.
//    - Next state is ACK; the pulse drops to 0 there. A pulse is always high for exactly
//      1 cycle and low for at least 1 cycle, so the mixer's edge detector sees every step.
//  - ACK: count cycles.
//    - weight1!=wprev: if weight1==tgt go to FINISH, else go to WAIT_RATE.
//    - count reaches ACK_TIMEOUT: set err, go to FINISH.
//  - FINISH: done=1 for 1 cycle; busy=0 in the same cycle; go to IDLE.
//  - Step latency: the first pulse comes rate ready strobes after start. The mixer updates
//    weight1 2 cycles after the pulse, within the ACK window.
//  - abort, any busy state: next cycle state=IDLE, fup=fdown=0, busy=0, no done pulse.
//    abort wins over a simultaneous start or ready.
//  - reset mid-fade: everything returns to reset values at once; no partial pulse is emitted.
//  - weight1 moving externally mid-fade: direction is re-evaluated at every PULSE, so the
//    sequencer tracks the target and never overshoots.
// CONFIGURATION
//  - XFADE_PINGPONG_EN defined:
//    - On start, also latch origin=weight1.
//    - On reaching tgt, go to WAIT_RATE again with tgt=origin (one return leg, same rate).
//    - done pulses only after the return leg completes. err on either leg ends the sequence.
//  - XFADE_PINGPONG_EN undefined: single leg only; no origin register.
// TESTING
//  - Reset with weight1=16 -> controls=0, busy=0, done=0, err=0; src_sel=8'h04 gives controls[7:0]=8'h04 next cycle.
//  - Model mixer; weight1=16, start target=20 rate=2 -> 4 fup pulses, 2 ready strobes apart; weight1=20; done x1; err=0.
//  - weight1=16, start target=16 -> no pulses; busy high 1 cycle; done pulse on the 2nd cycle after start.
//  - Mixer model ignores pulses, start target=10 -> one fdown, ACK_TIMEOUT cycles, err=1, done pulse, IDLE.
//  - start target=0 rate=1, abort after 3 steps -> weight1=13, busy=0, no done, later pulses suppressed.
//  - busy, man_fup toggled -> controls[8] stays 0 except scheduled steps; in IDLE, man_fup passes through 1 cycle later.
//  - XFADE_PINGPONG_EN: weight1=16, target=18 -> 2 fup then 2 fdown; weight1=16; a single done.

Source files
------------

// File: rtl/crossfade_sequencer.sv
// Crossfade sequencer: steps the mixer's weight1 toward a target with fup/fdown pulses.
// Optional return leg to the starting weight when XFADE_PINGPONG_EN is defined.
module crossfade_sequencer #(
    parameter logic [4:0] MAX_WEIGHT  = 5'd31,
    parameter int         ACK_TIMEOUT = 8,
    parameter int         RATE_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ready,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        target,
    input  logic [RATE_W-1:0] rate,
    input  logic [4:0]        weight1,
    input  logic              man_fup,
    input  logic              man_fdown,
    input  logic [7:0]        src_sel,
    output logic [9:0]        controls,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RATE,
        PULSE,
        ACK,
        FINISH
    } state_t;

    localparam int                ACK_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ACK_W-1:0]  ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [ACK_W-1:0]  ACK_ONE  = ACK_W'(1);
    localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

    state_t            state, state_n;
    logic [4:0]        tgt, tgt_n;
    logic [4:0]        wprev, wprev_n;
    logic [4:0]        tgt_clamp;
    logic [RATE_W-1:0] rate_q, rate_n;
    logic [RATE_W-1:0] rcnt, rcnt_n;
    logic [ACK_W-1:0]  acnt, acnt_n;
    logic [1:0]        ctrl_hi_n;
    logic [1:0]        step_n;
    logic              busy_n, done_n, err_n;
    logic              arrived;
`ifdef XFADE_PINGPONG_EN
    logic [4:0]        origin, origin_n;
    logic              leg, leg_n;
`endif

    assign tgt_clamp = (target > MAX_WEIGHT) ? MAX_WEIGHT : target;

    always_comb begin
        state_n  = state;
        tgt_n    = tgt;
        wprev_n  = wprev;
        rate_n   = rate_q;
        rcnt_n   = rcnt;
        acnt_n   = acnt;
        step_n   = 2'b00;
        err_n    = err;
        arrived  = 1'b0;
`ifdef XFADE_PINGPONG_EN
        origin_n = origin;
        leg_n    = leg;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    tgt_n   = tgt_clamp;
                    rate_n  = (rate == '0) ? RATE_ONE : rate;
                    err_n   = 1'b0;
                    rcnt_n  = '0;
                    acnt_n  = '0;
`ifdef XFADE_PINGPONG_EN
                    origin_n = weight1;
                    leg_n    = 1'b0;
`endif
                    state_n = (tgt_clamp == weight1) ? FINISH : WAIT_RATE;
                end
            end
            WAIT_RATE: begin
                if (ready) begin
                    if (rcnt == rate_q - RATE_ONE) begin
                        rcnt_n = '0;
                        // weight1 may have been moved externally onto the target
                        if (weight1 == tgt) begin
                            arrived = 1'b1;
                        end else begin
                            wprev_n = weight1;
                            step_n  = (weight1 < tgt) ? 2'b01 : 2'b10;
                            state_n = PULSE;
                        end
                    end else begin
                        rcnt_n = rcnt + RATE_ONE;
                    end
                end
            end
            PULSE: begin
                acnt_n  = '0;
                state_n = ACK;
            end
            ACK: begin
                if (weight1 != wprev) begin
                    acnt_n = '0;
                    if (weight1 == tgt) arrived = 1'b1;
                    else                state_n = WAIT_RATE;
                end else if (acnt == ACK_LAST) begin
                    acnt_n  = '0;
                    err_n   = 1'b1;
                    state_n = FINISH;
                end else begin
                    acnt_n = acnt + ACK_ONE;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (arrived) begin
`ifdef XFADE_PINGPONG_EN
            if (!leg) begin
                leg_n   = 1'b1;
                tgt_n   = origin;
                state_n = WAIT_RATE;
            end else begin
                state_n = FINISH;
            end
`else
            state_n = FINISH;
`endif
        end

        // abort overrides everything, including a pulse about to be issued
        if (abort && state != IDLE) begin
            state_n = IDLE;
            step_n  = 2'b00;
            rcnt_n  = '0;
            acnt_n  = '0;
        end

        busy_n    = (state_n != IDLE);
        done_n    = (state == FINISH) && !abort;
        ctrl_hi_n = (state == IDLE) ? {man_fdown, man_fup} : step_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tgt      <= '0;
            wprev    <= '0;
            rate_q   <= '0;
            rcnt     <= '0;
            acnt     <= '0;
            controls <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef XFADE_PINGPONG_EN
            origin   <= '0;
            leg      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            tgt      <= tgt_n;
            wprev    <= wprev_n;
            rate_q   <= rate_n;
            rcnt     <= rcnt_n;
            acnt     <= acnt_n;
            controls <= {ctrl_hi_n, src_sel};
            busy     <= busy_n;
            done     <= done_n;
            err      <= err_n;
`ifdef XFADE_PINGPONG_EN
            origin   <= origin_n;
            leg      <= leg_n;
`endif
        end
    end

endmodule
